// File: rtl/fp24_div_pkg.sv
// Shared fp24 format: sign[23], exp[22:16] (bias 63), mant[15:0] with implicit leading 1.
// No denormals or NaN; zero is exp==0 && mant==0.
package fp24_div_pkg;

  localparam int FP24_BIAS   = 63;
  localparam int FP24_MANT_W = 16;
  localparam logic [6:0] FP24_EXP_MAX = 7'h7F;

  typedef struct packed {
    logic                   sign;
    logic [6:0]             exp;
    logic [FP24_MANT_W-1:0] mant;
  } fp24_t;

  localparam fp24_t FP24_ZERO = '0;

  function automatic logic fp24_is_zero(input fp24_t x);
    return (x.exp == 7'd0) && (x.mant == '0);
  endfunction

endpackage

// File: rtl/fp24_div_step.sv
// One combinational restoring-division step: subtract when possible, emit the quotient bit,
// and return the shifted partial remainder. No state, no latency, no backpressure.
module fp24_div_step
  import fp24_div_pkg::*;
(
  input  logic [FP24_MANT_W+2:0] rem,
  input  logic [FP24_MANT_W:0]   div,
  output logic [FP24_MANT_W+2:0] rem_next,
  output logic                   qbit
);

  logic [FP24_MANT_W+2:0] div_ext;
  logic [FP24_MANT_W+2:0] rem_sub;

  always_comb begin
    div_ext  = {2'b00, div};
    qbit     = (rem >= div_ext);
    rem_sub  = qbit ? (rem - div_ext) : rem;
    rem_next = rem_sub << 1;
  end

endmodule

// File: rtl/fp24_div.sv
// fp24 divider quot = a / b, one restoring quotient bit per cycle; 19-cycle fixed latency.
// One operation in flight: in_ready is high only in IDLE, and requests made while busy are ignored.
module fp24_div
  import fp24_div_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  fp24_t a,
  input  fp24_t b,
  input  logic  in_valid,
  output logic  in_ready,
  output fp24_t quot,
  output logic  out_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;

  localparam logic [4:0] LAST_ITER = 5'd17;

  logic [1:0]             state_q,     state_d;
  logic [4:0]             cnt_q,       cnt_d;
  logic [FP24_MANT_W+2:0] rem_q,       rem_d;
  logic [FP24_MANT_W:0]   div_q,       div_d;
  logic [FP24_MANT_W+1:0] q_q,         q_d;
  logic                   sign_q,      sign_d;
  logic signed [8:0]      ediff_q,     ediff_d;
  logic                   a_zero_q,    a_zero_d;
  logic                   b_zero_q,    b_zero_d;
  fp24_t                  quot_q,      quot_d;
  logic                   out_valid_q, out_valid_d;

  logic [FP24_MANT_W+2:0] rem_step;
  logic                   qbit;
  logic signed [8:0]      e_adj;
  logic [FP24_MANT_W-1:0] mant_n;

  fp24_div_step u_step (
    .rem      (rem_q),
    .div      (div_q),
    .rem_next (rem_step),
    .qbit     (qbit)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign quot      = quot_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    div_d       = div_q;
    q_d         = q_q;
    sign_d      = sign_q;
    ediff_d     = ediff_q;
    a_zero_d    = a_zero_q;
    b_zero_d    = b_zero_q;
    quot_d      = quot_q;
    out_valid_d = 1'b0;

    // q lies in (2^16, 2^18): the top bit tells whether the ratio of fractions is >= 1
    e_adj  = ediff_q + (q_q[FP24_MANT_W+1] ? 9'(FP24_BIAS) : 9'(FP24_BIAS - 1));
    mant_n = q_q[FP24_MANT_W+1] ? q_q[FP24_MANT_W:1] : q_q[FP24_MANT_W-1:0];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d   = a.sign ^ b.sign;
          ediff_d  = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp});
          a_zero_d = fp24_is_zero(a);
          b_zero_d = fp24_is_zero(b);
          rem_d    = {2'b00, 1'b1, a.mant};
          div_d    = {1'b1, b.mant};
          q_d      = '0;
          cnt_d    = '0;
          state_d  = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        q_d   = {q_q[FP24_MANT_W:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
        if (a_zero_q) begin
          quot_d = {sign_q, 23'h0};
        end else if (b_zero_q) begin
          quot_d = {sign_q, FP24_EXP_MAX, 16'h0};
        end else if (e_adj < 9'sd1) begin
          quot_d = {sign_q, 23'h0};
        end else if (e_adj > 9'sd127) begin
          quot_d = {sign_q, FP24_EXP_MAX, 16'h0};
        end else begin
          quot_d = {sign_q, e_adj[6:0], mant_n};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      sign_q      <= 1'b0;
      ediff_q     <= '0;
      a_zero_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      quot_q      <= FP24_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      q_q         <= q_d;
      sign_q      <= sign_d;
      ediff_q     <= ediff_d;
      a_zero_q    <= a_zero_d;
      b_zero_q    <= b_zero_d;
      quot_q      <= quot_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp24_div.sv
// Bench for fp24_div: fixed vectors, handshake and reset-abort sequences, then random
// operands against a truncating reference, all checked through an accept-time scoreboard.
module tb_fp24_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] a;
  logic [23:0] b;
  logic [23:0] quot;

  fp24_div dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quot      (quot),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] q;
    int          acc;
  } sb_t;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] q;
  } vec_t;

  sb_t         sb_q[$];
  int          acc_log[$];
  vec_t        vecs[13];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          use_tbl = 1'b0;
  logic [23:0] tbl_exp = '0;
  logic [23:0] last_quot = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ref_div(input logic [23:0] x, input logic [23:0] y);
    logic        s;
    longint      fa, fb, q;
    int          e;
    logic [15:0] m;
    s = x[23] ^ y[23];
    if (x[22:0] == 23'h0) return {s, 23'h0};
    if (y[22:0] == 23'h0) return {s, 7'h7F, 16'h0};
    fa = longint'({1'b1, x[15:0]});
    fb = longint'({1'b1, y[15:0]});
    q  = (fa << 17) / fb;
    if (q >= 64'd131072) begin
      m = 16'((q >> 1) & 64'hFFFF);
      e = int'(x[22:16]) - int'(y[22:16]) + 63;
    end else begin
      m = 16'(q & 64'hFFFF);
      e = int'(x[22:16]) - int'(y[22:16]) + 62;
    end
    if (e < 1) return {s, 23'h0};
    if (e > 127) return {s, 7'h7F, 16'h0};
    return {s, 7'(e), m};
  endfunction

  function automatic logic [23:0] rnd_norm();
    return {1'($urandom), 7'($urandom_range(127, 1)), 16'($urandom)};
  endfunction

  // Outputs are sampled mid-cycle; inputs seen here are what the next rising edge will use.
  always @(negedge clk) begin
    sb_t e;
    if (mon_en) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk(1'b0, "unexpected_out_valid", quot, 24'h0);
        end else begin
          e = sb_q.pop_front();
          chk(quot === e.q, "quot", quot, e.q);
          chk((cyc - e.acc) == 19, "latency", 24'(cyc - e.acc), 24'd19);
        end
        last_quot = quot;
      end else begin
        chk(quot === last_quot, "quot_hold", quot, last_quot);
      end
    end
    if (!rst && in_valid && in_ready) begin
      e.q   = use_tbl ? tbl_exp : ref_div(a, b);
      e.acc = cyc + 1;
      sb_q.push_back(e);
      acc_log.push_back(cyc + 1);
    end
  end

  task automatic op(input logic [23:0] xa, input logic [23:0] xb, input logic [23:0] xq, input bit tbl);
    bit took;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    tbl_exp  = xq;
    use_tbl  = tbl;
    took     = 1'b0;
    for (int k = 0; k < 50 && !took; k++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    chk(took, "accept_timeout", 24'(took), 24'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(sb_q.size() == 0, "drain_timeout", 24'(sb_q.size()), 24'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0]  = '{24'h418000, 24'h400000, 24'h408000};
    vecs[1]  = '{24'h3F0000, 24'h408000, 24'h3D5555};
    vecs[2]  = '{24'hBF0000, 24'h408000, 24'hBD5555};
    vecs[3]  = '{24'h000000, 24'h408000, 24'h000000};
    vecs[4]  = '{24'h3F0000, 24'h000000, 24'h7F0000};
    vecs[5]  = '{24'h800000, 24'h000000, 24'h800000};
    vecs[6]  = '{24'h7F0000, 24'h010000, 24'h7F0000};
    vecs[7]  = '{24'h010000, 24'h7F0000, 24'h000000};
    vecs[8]  = '{24'h3F0000, 24'h3F0000, 24'h3F0000};
    vecs[9]  = '{24'hC18000, 24'h400000, 24'hC08000};
    vecs[10] = '{24'h3F0000, 24'h800000, 24'hFF0000};
    vecs[11] = '{24'h400000, 24'hBF0000, 24'hC00000};
    vecs[12] = '{24'h000000, 24'h000000, 24'h000000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(in_ready === 1'b1, "reset_in_ready", 24'(in_ready), 24'd1);
    chk(out_valid === 1'b0, "reset_out_valid", 24'(out_valid), 24'd0);
    chk(quot === 24'h0, "reset_quot", quot, 24'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    last_quot = '0;
    mon_en    = 1'b1;

    for (int i = 0; i < 13; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].q, 1'b1);
    end
    drain();

    // in_valid held high while operands change every cycle: only idle-time accepts count
    acc_log.delete();
    use_tbl  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      a = rnd_norm();
      b = rnd_norm();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk(acc_log.size() == 3, "busy_accept_count", 24'(acc_log.size()), 24'd3);
    for (int i = 1; i < acc_log.size(); i++) begin
      chk((acc_log[i] - acc_log[i-1]) == 20, "accept_spacing",
          24'(acc_log[i] - acc_log[i-1]), 24'd20);
    end
    drain();

    // Abort in the middle of the iteration: the op must vanish without a pulse
    op(24'h418000, 24'h400000, 24'h408000, 1'b1);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst    = 1'b1;
    mon_en = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk(in_ready === 1'b1, "abort_in_ready", 24'(in_ready), 24'd1);
    chk(out_valid === 1'b0, "abort_out_valid", 24'(out_valid), 24'd0);
    chk(quot === 24'h0, "abort_quot", quot, 24'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    last_quot = '0;
    mon_en    = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
    end
    op(24'h418000, 24'h400000, 24'h408000, 1'b1);
    drain();

    for (int n = 0; n < 2000; n++) begin
      op(rnd_norm(), rnd_norm(), 24'h0, 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
